// File: rtl/demux_12_pkg.sv
// demux_12_pkg: shared widths, select encoding and FIFO depth for the demux_12 slice
package demux_12_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;
  localparam int FIFO_DEPTH = 2;
  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;
endpackage

// File: rtl/demux_12_fifo2.sv
// demux_12_fifo2: 2-entry valid/ready FIFO; readiness comes from registered occupancy only
module demux_12_fifo2
  import demux_12_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] push_data,
  input  logic         push_valid,
  output logic         push_ready,
  output logic [W-1:0] pop_data,
  output logic         pop_valid,
  input  logic         pop_ready
);
  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);
  logic [1:0]   cnt_q, cnt_d;
  logic         wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [W-1:0] mem_d [FIFO_DEPTH];
  logic         push, pop;
  assign push_ready = cnt_q != DEPTH;
  assign pop_valid  = cnt_q != 2'd0;
  assign pop_data   = pop_valid ? mem_q[rd_q] : '0;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  // next-state: write at wr pointer, advance pointers, net occupancy change
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_data;
    wr_d  = wr_q ^ push;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  // state registers; reset discards any buffered words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/demux_12.sv
// demux_12: 1-to-2 stream demux with a 2-entry FIFO per output; DEMUX_12_COUNT_EN adds transfer counters
module demux_12
  import demux_12_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] y_in,
  input  logic              y_valid_in,
  input  logic              sel_in,
  output logic              y_ready_out,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  input  logic              a_ready_in,
  output logic [DATA_W-1:0] b_out,
  output logic              b_valid_out,
  input  logic              b_ready_in
`ifdef DEMUX_12_COUNT_EN
  ,
  output logic [CNT_W-1:0]  a_cnt_out,
  output logic [CNT_W-1:0]  b_cnt_out
`endif
);
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
  sel_e sel;
  logic a_push_ready, b_push_ready;
  assign sel         = sel_e'(sel_in);
  assign y_ready_out = (sel == SEL_B) ? b_push_ready : a_push_ready;
  demux_12_fifo2 #(.W(DATA_W)) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_data (y_in),
    .push_valid(y_valid_in && sel == SEL_A),
    .push_ready(a_push_ready),
    .pop_data  (a_out),
    .pop_valid (a_valid_out),
    .pop_ready (a_ready_in)
  );
  demux_12_fifo2 #(.W(DATA_W)) u_fifo_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_data (y_in),
    .push_valid(y_valid_in && sel == SEL_B),
    .push_ready(b_push_ready),
    .pop_data  (b_out),
    .pop_valid (b_valid_out),
    .pop_ready (b_ready_in)
  );
`ifdef DEMUX_12_COUNT_EN
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  assign a_cnt_out = a_cnt_q;
  assign b_cnt_out = b_cnt_q;
  // count completed output handshakes; natural wrap at 2^CNT_W
  always_comb begin
    a_cnt_d = a_cnt_q + CNT_W'(a_valid_out && a_ready_in);
    b_cnt_d = b_cnt_q + CNT_W'(b_valid_out && b_ready_in);
  end
  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_demux_12.sv
// tb_demux_12: directed + random checks of demux_12 against a queue-based reference model
module tb_demux_12;
`ifdef DEMUX_12_COUNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] y_in;
  logic y_valid_in, sel_in, y_ready_out;
  logic [7:0] a_out, b_out;
  logic a_valid_out, b_valid_out, a_ready_in, b_ready_in;
`ifdef DEMUX_12_COUNT_EN
  logic [CNT_W-1:0] a_cnt_out, b_cnt_out;
`endif
  int tests = 0;
  int fails = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int ca = 0;
  int cb = 0;

  always #5 clk = ~clk;

  demux_12 #(.DATA_W(8), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .y_in       (y_in),
    .y_valid_in (y_valid_in),
    .sel_in     (sel_in),
    .y_ready_out(y_ready_out),
    .a_out      (a_out),
    .a_valid_out(a_valid_out),
    .a_ready_in (a_ready_in),
    .b_out      (b_out),
    .b_valid_out(b_valid_out),
    .b_ready_in (b_ready_in)
`ifdef DEMUX_12_COUNT_EN
    ,
    .a_cnt_out  (a_cnt_out),
    .b_cnt_out  (b_cnt_out)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic s);
    chk("y_ready", y_ready_out, s ? (qb.size() < 2) : (qa.size() < 2));
    chk("a_valid", a_valid_out, qa.size() > 0);
    chk("a_out", a_out, qa.size() > 0 ? qa[0] : 8'h00);
    chk("b_valid", b_valid_out, qb.size() > 0);
    chk("b_out", b_out, qb.size() > 0 ? qb[0] : 8'h00);
`ifdef DEMUX_12_COUNT_EN
    chk("a_cnt", a_cnt_out, ca % (1 << CNT_W));
    chk("b_cnt", b_cnt_out, cb % (1 << CNT_W));
`endif
  endtask

  task automatic cyc(input logic v, input logic s, input logic [7:0] d, input logic ar, input logic br);
    logic acc, pa, pb;
    y_valid_in = v;
    sel_in     = s;
    y_in       = d;
    a_ready_in = ar;
    b_ready_in = br;
    @(negedge clk);
    check_outputs(s);
    acc = v && (s ? qb.size() < 2 : qa.size() < 2);
    pa  = ar && qa.size() > 0;
    pb  = br && qb.size() > 0;
    @(posedge clk);
    if (pa) begin void'(qa.pop_front()); ca++; end
    if (pb) begin void'(qb.pop_front()); cb++; end
    if (acc) begin
      if (s) qb.push_back(d);
      else qa.push_back(d);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_a_valid", a_valid_out, 1'b0);
    chk("rst_b_valid", b_valid_out, 1'b0);
    chk("rst_a_out", a_out, 8'h00);
    chk("rst_b_out", b_out, 8'h00);
    chk("rst_y_ready", y_ready_out, 1'b1);
`ifdef DEMUX_12_COUNT_EN
    chk("rst_a_cnt", a_cnt_out, 0);
    chk("rst_b_cnt", b_cnt_out, 0);
`endif
    qa.delete();
    qb.delete();
    ca = 0;
    cb = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    y_in = '0;
    y_valid_in = 1'b0;
    sel_in = 1'b0;
    a_ready_in = 1'b0;
    b_ready_in = 1'b0;
    #2;
    do_reset();
    // single word to A, visible next cycle
    cyc(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    chk("t30_a_valid", a_valid_out, 1'b1);
    chk("t30_a_out", a_out, 8'h3C);
    chk("t30_b_valid", b_valid_out, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    // fill B while stalled, then drain in order
    cyc(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
    sel_in = 1'b1;
    #1;
    chk("t31_ready_sel_b", y_ready_out, 1'b0);
    sel_in = 1'b0;
    #1;
    chk("t31_ready_sel_a", y_ready_out, 1'b1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("t31_b_head", b_out, 8'h11);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("t31_b_second", b_out, 8'h22);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("t31_b_empty", b_valid_out, 1'b0);
    // back-to-back stream into A at full rate
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 8'(8'hA0 + i), 1'b1, 1'b0);
      chk("t32_ready", y_ready_out, 1'b1);
      chk("t32_a_out", a_out, 8'(8'hA0 + i));
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    // random traffic, alternating destinations
    for (int i = 0; i < 300; i++)
      cyc(($urandom % 4) != 0, 1'(i % 2), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    // fill both FIFOs, then reset mid-cycle
    cyc(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
    chk("t34_a_full", a_valid_out, 1'b1);
    #2;
    do_reset();
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    chk("t34_fresh_b", b_out, 8'h5A);
    chk("t34_no_stale_a", a_valid_out, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
`ifdef DEMUX_12_COUNT_EN
    #2;
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t35_a_cnt", a_cnt_out, 1);
    chk("t35_b_cnt", b_cnt_out, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/demux_12.md
DEMUX_12 -- requirements
Module: demux_12

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width of input and both outputs.
REQ-002 SHALL have parameter CNT_W, default 16, width of transfer counters (used only with DEMUX_12_COUNT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port y_in  input  DATA_W  input stream data.
REQ-006 SHALL have port y_valid_in  input  1  input data valid.
REQ-007 SHALL have port sel_in  input  1  destination of current input word, 0=A, 1=B; qualified by y_valid_in.
REQ-008 SHALL have port y_ready_out  output  1  input accepted when y_valid_in and y_ready_out both high.
REQ-009 SHALL have ports a_out / b_out  output  DATA_W  output data, A and B.
REQ-010 SHALL have ports a_valid_out / b_valid_out  output  1  output valid, A and B.
REQ-011 SHALL have ports a_ready_in / b_ready_in  input  1  downstream ready, A and B.
REQ-012 SHALL have ports a_cnt_out / b_cnt_out  output  CNT_W  completed output transfers, present only with DEMUX_12_COUNT_EN.

Function
REQ-013 SHALL give each output (A, B) an independent 2-entry FIFO; an accepted input word SHALL be pushed only into the FIFO selected by sel_in.
REQ-014 SHALL drive y_ready_out = (sel_in ? B not full : A not full); "not full" SHALL come from a registered occupancy (count < 2), not from the same-cycle output ready.
REQ-015 SHALL make an accepted word visible on its output (valid high, data stable) on the cycle after acceptance; latency exactly 1 cycle when that FIFO was empty.
REQ-016 SHALL complete an output transfer when x_valid_out and x_ready_in are both high; the head entry SHALL pop on that edge.
REQ-017 SHALL hold x_out and x_valid_out stable while x_valid_out is high and x_ready_in is low.
REQ-018 SHALL preserve word order per output; no ordering guarantee between A and B.
REQ-019 SHALL, on simultaneous push and pop on the same FIFO, leave occupancy unchanged and sustain 1 word/cycle throughput.
REQ-020 SHALL, when a FIFO is full, deassert y_ready_out only while sel_in selects that FIFO; words for the other output SHALL still be accepted.
REQ-021 SHALL ignore sel_in and y_in when y_valid_in is low; no FIFO state changes.
REQ-022 SHALL never overflow or underflow a FIFO; pops on empty and pushes on full SHALL be impossible by construction.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear both FIFO occupancies and pointers to 0.
REQ-024 SHALL drive a_valid_out=0, b_valid_out=0, a_out=0, b_out=0, a_cnt_out=0, b_cnt_out=0 during reset; y_ready_out follows REQ-014 with empty FIFOs, i.e. 1.
REQ-025 SHALL discard buffered words on reset asserted mid-operation; first valid output after release SHALL be a word accepted after release.

Configuration
REQ-026 SHALL, with macro DEMUX_12_COUNT_EN defined, include a_cnt_out/b_cnt_out, each incrementing by 1 per completed output transfer on its port and wrapping from 2^CNT_W-1 to 0.
REQ-027 SHALL, without DEMUX_12_COUNT_EN, omit the counter ports and logic entirely; all other behaviour identical.

Structure
REQ-028 SHALL place DATA_W/CNT_W defaults, the select enum (SEL_A=1'b0, SEL_B=1'b1) and FIFO depth constant (2) in package demux_12_pkg.
REQ-029 SHALL implement each output buffer as one instance of sub-module demux_12_fifo2 (2-entry valid/ready FIFO), instantiated twice.

Verification
REQ-030 SHALL test: reset, then y_in=8'h3C, sel_in=0, valid 1 cycle -> a_valid_out=1 with a_out=8'h3C next cycle; b_valid_out stays 0.
REQ-031 SHALL test: b_ready_in=0, push 8'h11, 8'h22 to B -> y_ready_out=0 when sel_in=1, =1 when sel_in=0; raise b_ready_in -> 8'h11 then 8'h22 on b_out.
REQ-032 SHALL test: a_ready_in=1, 10 back-to-back words to A -> one word accepted and one output per cycle, y_ready_out never low.
REQ-033 SHALL test: alternate sel_in 0/1 with both readies random -> per-output order matches a scoreboard, no loss or duplication.
REQ-034 SHALL test: rst_n pulsed low with both FIFOs full -> all valids 0 immediately, y_ready_out=1, no stale word after release.
REQ-035 SHALL test (DEMUX_12_COUNT_EN, CNT_W=4): 17 transfers on A -> a_cnt_out=1 after wrap, b_cnt_out=0.
